// File: rtl/frog_pkg.sv
// Shared types and constants for the frog controllers.
package frog_pkg;

  typedef logic [3:0]        pos_t;
  typedef logic [15:0][15:0] plane_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam pos_t ROW_MIN = 4'd0;
  localparam pos_t ROW_MAX = 4'd15;
  localparam pos_t COL_MIN = 4'd0;
  localparam pos_t COL_MAX = 4'd15;

endpackage

// File: rtl/frog_btn_edge.sv
// Rising-edge detector for the four direction buttons; reports a direction
// only when exactly one button was newly pressed this clock.
module frog_btn_edge
  import frog_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output dir_t dir
);

  logic [3:0] cur, prev_q, rise;

  assign cur  = {up, down, left, right};
  assign rise = cur & ~prev_q;

  // History tracks the buttons every clock, independent of enable.
  always_ff @(posedge clock) begin
    if (reset) prev_q <= '0;
    else       prev_q <= cur;
  end

  always_comb begin
    dir = DIR_NONE;
    case (rise)
      4'b1000: dir = DIR_UP;
      4'b0100: dir = DIR_DOWN;
      4'b0010: dir = DIR_LEFT;
      4'b0001: dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
  end

endmodule

// File: rtl/frog_player2.sv
// Player-2 frog: position, car collision restart and win pulse on row 0.
// Optional hit freeze/blink when FROG2_HIT_FREEZE_EN is defined.
module frog_player2
  import frog_pkg::*;
#(
  parameter int START_ROW     = 15,
  parameter int START_COL     = 4,
  parameter int FREEZE_CYCLES = 8
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   up,
  input  logic   down,
  input  logic   left,
  input  logic   right,
  input  logic   enable,
  input  plane_t RedPixels,
  output logic   win,
  output plane_t GrnPixels2
);

  localparam pos_t START_R = pos_t'(START_ROW);
  localparam pos_t START_C = pos_t'(START_COL);

  pos_t row_q, col_q;
  logic win_q;
  dir_t dir;
  logic hit, restart, frozen, show;

  frog_btn_edge u_edge (
    .clock (clock),
    .reset (reset),
    .up    (up),
    .down  (down),
    .left  (left),
    .right (right),
    .dir   (dir)
  );

  assign hit     = RedPixels[row_q][col_q];
  assign restart = !win_q && (row_q != ROW_MIN) && hit;

`ifdef FROG2_HIT_FREEZE_EN
  localparam int FCW = $clog2(FREEZE_CYCLES + 2);
  logic [FCW-1:0] frz_q;
  logic           blink_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      frz_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      if (restart)           frz_q <= FCW'(FREEZE_CYCLES);
      else if (frz_q != '0)  frz_q <= frz_q - 1'b1;
      blink_q <= (frz_q != '0) ? ~blink_q : 1'b0;
    end
  end

  assign frozen = (frz_q != '0);
  assign show   = !blink_q;
`else
  assign frozen = 1'b0;
  assign show   = 1'b1;
`endif

  // Win and collision take precedence over any move in the same clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= START_R;
      col_q <= START_C;
      win_q <= 1'b0;
    end else if (win_q) begin
      win_q <= 1'b0;
    end else if (row_q == ROW_MIN) begin
      win_q <= 1'b1;
      row_q <= START_R;
      col_q <= START_C;
    end else if (restart) begin
      row_q <= START_R;
      col_q <= START_C;
    end else if (enable && !frozen) begin
      case (dir)
        DIR_UP:    if (row_q != ROW_MIN) row_q <= row_q - 1'b1;
        DIR_DOWN:  if (row_q != ROW_MAX) row_q <= row_q + 1'b1;
        DIR_LEFT:  if (col_q != COL_MAX) col_q <= col_q + 1'b1;
        DIR_RIGHT: if (col_q != COL_MIN) col_q <= col_q - 1'b1;
        default:   ;
      endcase
    end
  end

  assign win = win_q;

  always_comb begin
    GrnPixels2 = '0;
    if (enable && show) GrnPixels2[row_q][col_q] = 1'b1;
  end

endmodule

// File: tb/tb_frog_player2.sv
// Scoreboard bench for frog_player2: a game-rule model predicts each clock's
// display and win, a monitor compares after every rising edge.
module tb_frog_player2;
  import frog_pkg::*;

  typedef struct {
    plane_t grn;
    logic   win;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset, up, down, left, right, enable;
  plane_t RedPixels;
  logic   win;
  plane_t GrnPixels2;

  frog_player2 dut (
    .clock      (clock),
    .reset      (reset),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .enable     (enable),
    .RedPixels  (RedPixels),
    .win        (win),
    .GrnPixels2 (GrnPixels2)
  );

  always #5 clock = ~clock;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;

  // Stimulus-side variables and the reference game state.
  logic   rst_r = 1'b1;
  logic   en_r  = 1'b1;
  plane_t red_r = '0;
  int     mrow = 15, mcol = 4;
  bit     mwin = 0;
  bit [3:0] mprev = '0;

  // One clock of game rules; b = {up, down, left, right}.
  task automatic model(input bit [3:0] b);
    int   n;
    exp_t e;
    n = $countones(b & ~mprev);
    if (rst_r) begin
      mrow = 15; mcol = 4; mwin = 0;
    end else if (mwin) begin
      mwin = 0;
    end else if (mrow == 0) begin
      mwin = 1; mrow = 15; mcol = 4;
    end else if (red_r[mrow][mcol]) begin
      mrow = 15; mcol = 4;
    end else if (en_r && n == 1) begin
      if (b[3] && !mprev[3] && mrow > 0)  mrow = mrow - 1;
      if (b[2] && !mprev[2] && mrow < 15) mrow = mrow + 1;
      if (b[1] && !mprev[1] && mcol < 15) mcol = mcol + 1;
      if (b[0] && !mprev[0] && mcol > 0)  mcol = mcol - 1;
    end
    mprev = rst_r ? 4'b0 : b;
    e.grn = '0;
    if (en_r) e.grn[mrow][mcol] = 1'b1;
    e.win = mwin;
    sb.push_back(e);
  endtask

  task automatic tick(input bit [3:0] b);
    @(negedge clock);
    reset = rst_r;
    {up, down, left, right} = b;
    enable = en_r;
    RedPixels = red_r;
    model(b);
  endtask

  task automatic press(input bit [3:0] b);
    tick(b);
    tick(4'b0000);
  endtask

  task automatic do_reset();
    rst_r = 1'b1;
    tick(4'b0000);
    tick(4'b0000);
    rst_r = 1'b0;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (GrnPixels2 !== e.grn) begin
        bad++;
        $display("FAIL grn cyc=%0d got=%h exp=%h", cyc, GrnPixels2, e.grn);
      end
      total++;
      if (win !== e.win) begin
        bad++;
        $display("FAIL win cyc=%0d got=%b exp=%b", cyc, win, e.win);
      end
    end
  end

  initial begin
    reset = 1'b1; up = 0; down = 0; left = 0; right = 0;
    enable = 1'b1; RedPixels = '0;

    do_reset();
    tick(4'b0000);

    // Single step, then a held button.
    press(4'b1000);
    repeat (5) tick(4'b1000);
    tick(4'b0000);
    // Simultaneous presses are not legal moves.
    press(4'b1010);

    // Bottom and right edges.
    do_reset();
    press(4'b0100);
    repeat (5) press(4'b0001);
    repeat (13) press(4'b0010);
    press(4'b0010);

    // Driving into a car.
    do_reset();
    red_r[13][4] = 1'b1;
    press(4'b1000);
    press(4'b1000);
    tick(4'b0000);
    red_r = '0;

    // Reaching the top row.
    do_reset();
    repeat (15) press(4'b1000);
    repeat (3) tick(4'b0000);

    // Hidden frog ignores presses.
    press(4'b1000);
    en_r = 1'b0;
    press(4'b1000);
    press(4'b0010);
    en_r = 1'b1;
    tick(4'b0000);
    press(4'b0001);

    // Randomized play with sparse, occasionally changing cars.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit [3:0] b;
      if (i % 60 == 0) begin
        red_r = '0;
        for (int k = 0; k < int'($urandom_range(0, 3)); k++)
          red_r[$urandom_range(0, 14)][$urandom_range(0, 15)] = 1'b1;
      end
      en_r = ($urandom_range(0, 19) != 0);
      b = '0;
      if ($urandom_range(0, 2) == 0) b[3] = 1'b1;
      if ($urandom_range(0, 7) == 0) b[2] = 1'b1;
      if ($urandom_range(0, 5) == 0) b[1] = 1'b1;
      if ($urandom_range(0, 5) == 0) b[0] = 1'b1;
      tick(b);
      if (i == 700) do_reset();
    end

    repeat (3) @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frog_player2.md
Name: frog_player2

Overview:
- Player-2 frog controller for the two-player Frogger game on a 16x16 LED matrix.
- Holds the frog's row/column, steps it once per directional button press, and sends it back to start on a collision with a red (car) pixel.
- Pulses win when the frog reaches row 0.
- Drives the green plane for player 2; sits beside frog_player1 under the game top level.

Parameters:
- START_ROW, 15, row the frog starts at and returns to after collision or win.
- START_COL, 4, column the frog starts at and returns to after collision or win.
- FREEZE_CYCLES, 8, clocks of frozen input after a collision (only with the optional feature).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clock clock.
- up  input  1  button; moves the frog toward row 0.
- down  input  1  button; moves the frog toward row 15.
- left  input  1  button; column +1.
- right  input  1  button; column -1.
- enable  input  1  1 = frog active and displayed; 0 = frog hidden and frozen.
- RedPixels  input  16x16  packed [row][col] car plane; 1 = car present.
- win  output  1  one-clock pulse when the frog reaches row 0.
- GrnPixels2  output  16x16  packed [row][col] green plane; exactly one bit set at the frog position when enable=1.

Behaviour:
- State:
  - row register, 4 bits.
  - col register, 4 bits.
  - win register.
  - previous-value registers for up/down/left/right.
- Reset: row=START_ROW, col=START_COL, win=0, previous-button registers=0.
- Edge detection:
  - A press is a rising edge: current=1 and previous=1'b0, sampled at the clock edge.
  - Holding a button gives exactly one step.
  - Previous-button registers update every clock, including while enable=0.
- Legal move: exactly one rising edge among the four buttons in a cycle. Zero edges or multiple simultaneous edges means no move.
- Per-clock priority when not in reset:
  1. If win register = 1: clear win; position already at start; no move this cycle.
  2. Else if row == 0: win<=1 and position <= (START_ROW, START_COL). Win is therefore visible exactly one clock after the frog is displayed on row 0.
  3. Else if collision: position <= start. Collision = RedPixels[row][col]==1, evaluated combinationally on the current registered position.
  4. Else if enable=1 and a legal press occurs: apply the move.
  5. Else: hold.
- Boundaries:
  - Moves that would leave 0..15 (down at row 15, left at col 15, right at col 0) are ignored; no wrap.
  - Up at row 1 moves to row 0; the win rule fires on the next clock.
- Collision is checked before movement. A frog moving into a red pixel is displayed there for one clock, then restarts.
- enable=0: GrnPixels2 = all zeros, movement ignored, collision and win still evaluated.
- GrnPixels2 is combinational from the registers: zero except bit [row][col] when enable=1.
- Latency: button edge to new position = 1 clock.

Optional Feature:
- Macro FROG2_HIT_FREEZE_EN.
- Defined:
  - A collision loads a down-counter with FREEZE_CYCLES.
  - While the counter is non-zero, button presses are ignored and the frog pixel blinks, toggling every clock.
  - The counter decrements each clock; reset clears it.
- Undefined: no counter; presses are accepted on the clock after the restart.

Decomposition:
- Package frog_pkg:
  - typedef pos_t (logic [3:0]).
  - typedef plane_t (logic [15:0][15:0]).
  - enum dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
  - Localparam constants ROW_MIN=0 and ROW_MAX=15.
- Sub-module frog_btn_edge: one instance for all four buttons. Registers previous values and outputs dir_t, DIR_NONE when the press is not legal.

Test Plan:
- Reset, then RedPixels=0, enable=1 -> GrnPixels2 has only bit [15][4] set; win=0.
- Pulse up for one clock -> next clock row=14. Hold up for 5 clocks -> row decreases by exactly 1.
- From (15,4): press down -> stays at row 15. Press right 4 times -> col 0. Press right again -> col 0.
- Set RedPixels[13][4]=1, press up twice -> frog at (13,4) for one clock, then (15,4); win=0.
- Press up 15 times with RedPixels=0 -> frog shown at row 0, next clock win=1 and frog at (15,4), following clock win=0.
- enable=0 -> GrnPixels2=0 and presses ignored. Restore enable=1 -> frog shown at the unchanged position.
